// File: rtl/src_arbiter.sv
// Two-requester round-robin arbiter sharing one src datapath.
// A granted operation owns the datapath for LATENCY cycles; an overflow adds a one-cycle datapath clear.
module src_arbiter #(
  parameter int unsigned NB_data1  = 3,
  parameter int unsigned NB_data2  = 3,
  parameter int unsigned NB_o_sum2 = 6,
  parameter int unsigned LATENCY   = 2
) (
  input  logic                 clk,
  input  logic                 i_rst_n,
  input  logic                 i_req0,
  input  logic [1:0]           i_sel0,
  input  logic [NB_data1-1:0]  i_data1_0,
  input  logic [NB_data2-1:0]  i_data2_0,
  input  logic                 i_req1,
  input  logic [1:0]           i_sel1,
  input  logic [NB_data1-1:0]  i_data1_1,
  input  logic [NB_data2-1:0]  i_data2_1,
  output logic                 o_gnt0,
  output logic                 o_gnt1,
  output logic                 o_done0,
  output logic                 o_done1,
  output logic [1:0]           o_src_sel,
  output logic [NB_data1-1:0]  o_src_data1,
  output logic [NB_data2-1:0]  o_src_data2,
  output logic                 o_src_rst_n,
  input  logic [NB_o_sum2-1:0] i_src_data,
  input  logic                 i_src_overflow,
  output logic [NB_o_sum2-1:0] o_result,
  output logic                 o_result_ovf,
  output logic                 o_busy
);

  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
  logic                 r_ptr, w_ptr_nxt;
  logic                 r_owner, w_owner_nxt;
  logic                 r_gnt0, w_gnt0_nxt;
  logic                 r_gnt1, w_gnt1_nxt;
  logic                 r_done0, w_done0_nxt;
  logic                 r_done1, w_done1_nxt;
  logic [NB_o_sum2-1:0] r_result, w_result_nxt;
  logic                 r_ovf, w_ovf_nxt;
  logic [1:0]           r_sel, w_sel_nxt;
  logic [NB_data1-1:0]  r_d1, w_d1_nxt;
  logic [NB_data2-1:0]  r_d2, w_d2_nxt;
  logic                 r_busy;
  logic                 w_win;

  // State and registered outputs
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_ptr    <= 1'b0;
      r_owner  <= 1'b0;
      r_gnt0   <= 1'b0;
      r_gnt1   <= 1'b0;
      r_done0  <= 1'b0;
      r_done1  <= 1'b0;
      r_result <= '0;
      r_ovf    <= 1'b0;
      r_sel    <= '0;
      r_d1     <= '0;
      r_d2     <= '0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_ptr    <= w_ptr_nxt;
      r_owner  <= w_owner_nxt;
      r_gnt0   <= w_gnt0_nxt;
      r_gnt1   <= w_gnt1_nxt;
      r_done0  <= w_done0_nxt;
      r_done1  <= w_done1_nxt;
      r_result <= w_result_nxt;
      r_ovf    <= w_ovf_nxt;
      r_sel    <= w_sel_nxt;
      r_d1     <= w_d1_nxt;
      r_d2     <= w_d2_nxt;
      r_busy   <= (w_state_nxt != ST_IDLE);
    end
  end

  // Next-state, arbitration and capture
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_ptr_nxt    = r_ptr;
    w_owner_nxt  = r_owner;
    w_gnt0_nxt   = 1'b0;
    w_gnt1_nxt   = 1'b0;
    w_done0_nxt  = 1'b0;
    w_done1_nxt  = 1'b0;
    w_result_nxt = r_result;
    w_ovf_nxt    = r_ovf;
    w_sel_nxt    = r_sel;
    w_d1_nxt     = r_d1;
    w_d2_nxt     = r_d2;
    // pointer names the winner only under contention
    w_win        = (i_req0 && i_req1) ? r_ptr : i_req1;

    case (r_state)
      ST_IDLE: begin
        w_sel_nxt = '0;
        w_d1_nxt  = '0;
        w_d2_nxt  = '0;
        if (i_req0 || i_req1) begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = '0;
          w_owner_nxt = w_win;
          w_ptr_nxt   = ~w_win;
          w_gnt0_nxt  = ~w_win;
          w_gnt1_nxt  = w_win;
          w_sel_nxt   = w_win ? i_sel1    : i_sel0;
          w_d1_nxt    = w_win ? i_data1_1 : i_data1_0;
          w_d2_nxt    = w_win ? i_data2_1 : i_data2_0;
        end
      end
      ST_RUN: begin
        if (r_cnt == CNT_LAST) begin
          w_result_nxt = i_src_data;
          w_ovf_nxt    = i_src_overflow;
          w_done0_nxt  = ~r_owner;
          w_done1_nxt  = r_owner;
          w_cnt_nxt    = '0;
          w_sel_nxt    = '0;
          w_d1_nxt     = '0;
          w_d2_nxt     = '0;
          w_state_nxt  = i_src_overflow ? ST_CLEAR : ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_CLEAR: begin
        w_sel_nxt   = '0;
        w_d1_nxt    = '0;
        w_d2_nxt    = '0;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign o_gnt0       = r_gnt0;
  assign o_gnt1       = r_gnt1;
  assign o_done0      = r_done0;
  assign o_done1      = r_done1;
  assign o_src_sel    = r_sel;
  assign o_src_data1  = r_d1;
  assign o_src_data2  = r_d2;
  assign o_result     = r_result;
  assign o_result_ovf = r_ovf;
  assign o_busy       = r_busy;
  // datapath reset follows the system reset and is also pulsed during CLEAR
  assign o_src_rst_n  = i_rst_n & (r_state != ST_CLEAR);

endmodule

// File: tb/tb_src_arbiter.sv
// Directed bench for src_arbiter: the bench plays the src datapath and
// scoreboards every o_done against results queued when each request is driven.
module tb_src_arbiter;

  typedef struct packed {
    logic       owner;
    logic [5:0] res;
    logic       ovf;
  } exp_t;

  logic       clk = 1'b0;
  logic       i_rst_n;
  logic       i_req0, i_req1;
  logic [1:0] i_sel0, i_sel1;
  logic [2:0] i_data1_0, i_data2_0, i_data1_1, i_data2_1;
  logic       o_gnt0, o_gnt1, o_done0, o_done1;
  logic [1:0] o_src_sel;
  logic [2:0] o_src_data1, o_src_data2;
  logic       o_src_rst_n;
  logic [5:0] i_src_data;
  logic       i_src_overflow;
  logic [5:0] o_result;
  logic       o_result_ovf;
  logic       o_busy;

  logic       use_model;
  logic [5:0] f_data;
  logic       f_ovf;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  exp_t sb_q[$];
  int   gidx_q[$];
  int   gcyc_q[$];

  src_arbiter dut (
    .clk(clk), .i_rst_n(i_rst_n),
    .i_req0(i_req0), .i_sel0(i_sel0), .i_data1_0(i_data1_0), .i_data2_0(i_data2_0),
    .i_req1(i_req1), .i_sel1(i_sel1), .i_data1_1(i_data1_1), .i_data2_1(i_data2_1),
    .o_gnt0(o_gnt0), .o_gnt1(o_gnt1), .o_done0(o_done0), .o_done1(o_done1),
    .o_src_sel(o_src_sel), .o_src_data1(o_src_data1), .o_src_data2(o_src_data2),
    .o_src_rst_n(o_src_rst_n), .i_src_data(i_src_data), .i_src_overflow(i_src_overflow),
    .o_result(o_result), .o_result_ovf(o_result_ovf), .o_busy(o_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in datapath: result depends on every operand bit so latching errors show up
  function automatic logic [5:0] dp(input logic [1:0] s, input logic [2:0] a, input logic [2:0] b);
    return {s, 4'(4'(a) + 4'(b))};
  endfunction

  assign i_src_data     = use_model ? dp(o_src_sel, o_src_data1, o_src_data2) : f_data;
  assign i_src_overflow = use_model ? 1'b0 : f_ovf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ctl"}, 32'({o_gnt0, o_gnt1, o_done0, o_done1, o_busy}), 32'(0));
    chk({tag, "_res"}, 32'({o_result_ovf, o_result}), 32'(0));
    chk({tag, "_src"}, 32'({o_src_sel, o_src_data1, o_src_data2}), 32'(0));
    chk({tag, "_srst"}, 32'(o_src_rst_n), 32'(0));
  endtask

  task automatic wait_done(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (o_done0 || o_done1) begin
        seen = 1'b1;
        break;
      end
    end
    chk(tag, 32'(seen), 32'(1));
  endtask

  // Scoreboard and pulse monitor
  always @(negedge clk) begin
    exp_t e;
    if (o_gnt0 || o_gnt1) begin
      chk("gnt_excl", 32'(o_gnt0 & o_gnt1), 32'(0));
      gidx_q.push_back(o_gnt1 ? 1 : 0);
      gcyc_q.push_back(cyc);
    end
    if (o_done0 || o_done1) begin
      chk("done_excl", 32'(o_done0 & o_done1), 32'(0));
      if (sb_q.size() == 0) begin
        chk("done_unexpected", 32'(1), 32'(0));
      end else begin
        e = sb_q.pop_front();
        chk("done_owner", 32'(o_done1), 32'(e.owner));
        chk("result", 32'(o_result), 32'(e.res));
        chk("result_ovf", 32'(o_result_ovf), 32'(e.ovf));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, g, d, lowcnt;
    i_rst_n = 1'b0;
    i_req0 = 1'b0; i_sel0 = 2'd0; i_data1_0 = 3'd0; i_data2_0 = 3'd0;
    i_req1 = 1'b0; i_sel1 = 2'd0; i_data1_1 = 3'd0; i_data2_1 = 3'd0;
    use_model = 1'b0; f_data = 6'd0; f_ovf = 1'b0;

    // Reset state
    @(negedge clk);
    chk_reset("reset");
    @(negedge clk);
    i_rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_srst", 32'(o_src_rst_n), 32'(1));

    // Single request, forced datapath result 5
    i_req0 = 1'b1; i_sel0 = 2'b10; i_data1_0 = 3'd3; i_data2_0 = 3'd2;
    f_data = 6'd5;
    sb_q.push_back(exp_t'{owner: 1'b0, res: 6'd5, ovf: 1'b0});
    @(negedge clk);
    chk("s_gnt", 32'({o_gnt0, o_gnt1, o_busy}), 32'(3'b101));
    chk("s_src1", 32'({o_src_sel, o_src_data1, o_src_data2}), 32'({2'b10, 3'd3, 3'd2}));
    @(negedge clk);
    chk("s_gnt_pulse", 32'({o_gnt0, o_done0, o_busy}), 32'(3'b001));
    chk("s_src2", 32'({o_src_sel, o_src_data1, o_src_data2}), 32'({2'b10, 3'd3, 3'd2}));
    @(negedge clk);
    chk("s_done", 32'({o_done0, o_busy}), 32'(2'b10));
    chk("s_src_idle", 32'({o_src_sel, o_src_data1, o_src_data2}), 32'(0));
    i_req0 = 1'b0;
    @(negedge clk);
    chk("s_after", 32'({o_done0, o_gnt0, o_busy, o_result}), 32'({3'b000, 6'd5}));

    // Contention from reset: grants alternate 0,1,0,1 three cycles apart
    @(negedge clk);
    i_rst_n = 1'b0;
    #1 chk_reset("reset2");
    @(negedge clk);
    i_rst_n = 1'b1;
    use_model = 1'b1;
    gidx_q.delete(); gcyc_q.delete();
    i_req0 = 1'b1; i_sel0 = 2'd1; i_data1_0 = 3'd2; i_data2_0 = 3'd1;
    i_req1 = 1'b1; i_sel1 = 2'd3; i_data1_1 = 3'd5; i_data2_1 = 3'd6;
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) sb_q.push_back(exp_t'{owner: 1'b0, res: dp(2'd1, 3'd2, 3'd1), ovf: 1'b0});
      else            sb_q.push_back(exp_t'{owner: 1'b1, res: dp(2'd3, 3'd5, 3'd6), ovf: 1'b0});
    end
    n = 0;
    for (int i = 0; i < 40 && n < 4; i++) begin
      @(negedge clk);
      if (o_done0 || o_done1) n++;
    end
    i_req0 = 1'b0; i_req1 = 1'b0;
    chk("c_dones", 32'(n), 32'(4));
    repeat (5) @(negedge clk);
    chk("c_ngnt", 32'(gidx_q.size()), 32'(4));
    for (int k = 0; k < 4 && k < gidx_q.size(); k++) begin
      chk("c_gidx", 32'(gidx_q[k]), 32'(k % 2));
      if (k > 0) chk("c_gap", 32'(gcyc_q[k] - gcyc_q[k-1]), 32'(3));
    end

    // Overflow on requester 1: one-cycle datapath clear, grants four cycles apart
    use_model = 1'b0; f_data = 6'h2A; f_ovf = 1'b1;
    gidx_q.delete(); gcyc_q.delete();
    i_req1 = 1'b1; i_sel1 = 2'b01; i_data1_1 = 3'd7; i_data2_1 = 3'd7;
    sb_q.push_back(exp_t'{owner: 1'b1, res: 6'h2A, ovf: 1'b1});
    sb_q.push_back(exp_t'{owner: 1'b1, res: 6'h2A, ovf: 1'b1});
    g = 0; d = 0; lowcnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (o_gnt1) g++;
      if (g == 1 && !o_src_rst_n) lowcnt++;
      if (o_done1) begin
        d++;
        if (d == 1) begin
          chk("o_clear", 32'({o_src_rst_n, o_busy, o_src_sel, o_src_data1, o_src_data2}),
              32'({1'b0, 1'b1, 8'd0}));
        end else begin
          i_req1 = 1'b0;
          break;
        end
      end
    end
    chk("o_dones", 32'(d), 32'(2));
    chk("o_lowcnt", 32'(lowcnt), 32'(1));
    if (gcyc_q.size() >= 2) chk("o_gap", 32'(gcyc_q[1] - gcyc_q[0]), 32'(4));
    else chk("o_ngnt", 32'(gcyc_q.size()), 32'(2));
    f_ovf = 1'b0;
    repeat (3) @(negedge clk);
    chk("o_recover", 32'({o_src_rst_n, o_busy}), 32'(2'b10));

    // Operands changed mid-RUN are ignored
    use_model = 1'b1;
    i_req0 = 1'b1; i_sel0 = 2'd0; i_data1_0 = 3'd5; i_data2_0 = 3'd3;
    sb_q.push_back(exp_t'{owner: 1'b0, res: dp(2'd0, 3'd5, 3'd3), ovf: 1'b0});
    @(negedge clk);
    chk("m_gnt", 32'(o_gnt0), 32'(1));
    i_data1_0 = 3'd0; i_sel0 = 2'd3; i_data2_0 = 3'd1;
    @(negedge clk);
    chk("m_src", 32'({o_src_sel, o_src_data1, o_src_data2}), 32'({2'd0, 3'd5, 3'd3}));
    wait_done("m_done");
    i_req0 = 1'b0;
    @(negedge clk);

    // Reset during RUN (counter=1): aborted op, immediate re-grant after release
    i_req0 = 1'b1; i_sel0 = 2'd1; i_data1_0 = 3'd1; i_data2_0 = 3'd1;
    @(negedge clk);
    chk("r_gnt", 32'(o_gnt0), 32'(1));
    @(negedge clk);
    i_rst_n = 1'b0;
    #1 chk_reset("r_abort");
    @(negedge clk);
    chk("r_nodone", 32'({o_done0, o_done1}), 32'(0));
    sb_q.push_back(exp_t'{owner: 1'b0, res: dp(2'd1, 3'd1, 3'd1), ovf: 1'b0});
    i_rst_n = 1'b1;
    @(negedge clk);
    chk("r_regrant", 32'({o_gnt0, o_busy}), 32'(2'b11));
    wait_done("r_done");
    i_req0 = 1'b0;

    // Idle: no requests for 10 cycles
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle", 32'({o_busy, o_gnt0, o_gnt1, o_done0, o_done1, o_src_rst_n,
                       o_src_sel, o_src_data1, o_src_data2}),
          32'({5'b00000, 1'b1, 8'd0}));
    end

    chk("sb_empty", 32'(sb_q.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/src_arbiter.md
SRC_ARBITER -- requirements
Module: src_arbiter

Interface
REQ-001 Parameter NB_data1, default 3, width of operand 1.
REQ-002 Parameter NB_data2, default 3, width of operand 2.
REQ-003 Parameter NB_o_sum2, default 6, width of src result.
REQ-004 Parameter LATENCY, default 2, cycles from operands applied to src result valid (>=1).
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 i_rst_n  in  1  asynchronous active-low reset.
REQ-007 i_reqN  in  1  request from requester N (N=0,1); level, held until o_doneN.
REQ-008 i_selN  in  2  operation select from requester N.
REQ-009 i_data1_N / i_data2_N  in  NB_data1 / NB_data2  operands from requester N.
REQ-010 o_gntN  out  1  one-cycle pulse, operands of requester N latched.
REQ-011 o_doneN  out  1  one-cycle pulse, o_result/o_result_ovf valid for requester N.
REQ-012 o_src_sel / o_src_data1 / o_src_data2  out  2 / NB_data1 / NB_data2  drive shared src datapath.
REQ-013 o_src_rst_n  out  1  active-low reset to src datapath.
REQ-014 i_src_data / i_src_overflow  in  NB_o_sum2 / 1  src datapath result and overflow flag.
REQ-015 o_result / o_result_ovf  out  NB_o_sum2 / 1  captured result and overflow, held until next capture.
REQ-016 o_busy  out  1  high in any state other than IDLE.

Function
REQ-017 FSM states IDLE, RUN, CLEAR; encoding free.
REQ-018 IDLE: no request -> stay; o_src_sel/o_src_data1/o_src_data2 driven 0.
REQ-019 IDLE, request(s) at edge E0 -> winner's sel/data1/data2 latched, RUN entered, counter=0, o_gntN high for cycle after E0.
REQ-020 Only one requester -> that one wins; both -> requester named by round-robin pointer wins.
REQ-021 Pointer updates on each grant to point at the non-granted requester; reset value 0.
REQ-022 RUN: latched operands driven unchanged on o_src_*; counter increments each edge.
REQ-023 At edge E0+LATENCY: o_result<=i_src_data, o_result_ovf<=i_src_overflow, o_doneN high for following cycle for owning requester only.
REQ-024 Same edge: i_src_overflow=1 -> CLEAR, else -> IDLE.
REQ-025 CLEAR: one cycle; o_src_rst_n low, o_src_* driven 0; then IDLE.
REQ-026 o_src_rst_n = i_rst_n AND NOT(state==CLEAR); no other source.
REQ-027 Requests, sel or data changes outside IDLE sampling edge ignored; no queuing, no preemption.
REQ-028 Throughput: back-to-back ops spaced LATENCY+1 cycles without overflow, LATENCY+2 with overflow.
REQ-029 o_gnt0/o_gnt1 never simultaneously high; same for o_done0/o_done1.
REQ-030 Result widths fixed; no arithmetic performed on i_src_data (captured verbatim).

Reset
REQ-031 i_rst_n low -> immediately: state IDLE, counter 0, pointer 0, all o_gnt/o_done 0, o_busy 0, o_result 0, o_result_ovf 0, o_src_* 0, o_src_rst_n 0.
REQ-032 Reset mid-RUN/CLEAR aborts operation; no o_done issued for aborted op; after release, in-flight requester must still hold i_reqN to be re-granted.
REQ-033 First grant possible at first rising edge after i_rst_n release.

Verification
REQ-034 Single req: i_req0=1, i_sel0=2'b10, data 3/2 -> o_gnt0 one cycle, o_src_sel=2'b10, o_src_data1=3, o_src_data2=2 for 2 cycles; bench drives i_src_data=6'd5 -> o_result=5, o_done0 pulse at E0+2, o_busy low after.
REQ-035 Contention: i_req0=i_req1=1 from reset -> grants order 0,1,0,1; each o_done matches preceding o_gnt index; grants 3 cycles apart.
REQ-036 Overflow: i_req1, sel=2'b01, data 7/7, i_src_overflow=1 at sample edge -> o_result_ovf=1, o_done1 pulse, o_src_rst_n low exactly 1 cycle, next grant 4 cycles after previous.
REQ-037 Operand change mid-RUN: alter i_data1_0 to 0 after grant -> o_src_data1 keeps latched value until RUN exits.
REQ-038 Reset mid-RUN: assert i_rst_n low in RUN counter=1 -> all outputs reset values instantly, no o_done; release with i_req0 held -> fresh o_gnt0 on first edge.
REQ-039 Idle: no requests for 10 cycles -> o_busy=0, o_src_*=0, o_src_rst_n=1, no pulses.
